// File: rtl/seq_divider16.sv
// seq_divider16 - iterative unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a division; sampled in IDLE and in the DONE cycle
//   a_in, b_in   dividend / divisor, latched when start is accepted
//   busy         high for the WIDTH iteration cycles
//   done         one-cycle pulse marking q_out/r_out/div_by_zero valid
//   q_out, r_out quotient / remainder, held until the next done
//   div_by_zero  set with done when the latched divisor was zero
module seq_divider16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;      // partial remainder, always < B between iterations
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;

  // Single iteration datapath. The shifted remainder is held at WIDTH+1 bits
  // so the trial subtraction cannot overflow; because R < B is invariant, the
  // stored remainder only ever needs WIDTH bits.
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH-1:0] r_iter;
  logic [WIDTH-1:0] a_iter;

  always_comb begin
    r_shift   = {r_q, a_q[WIDTH-1]};
    // a - b as a + ~b + 1; bit WIDTH clear means r_shift >= B.
    trial     = r_shift + ~{1'b0, b_q} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow = ~trial[WIDTH];
    r_iter    = no_borrow ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
    a_iter    = {a_q[WIDTH-2:0], no_borrow};
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    q_out_d  = q_out_q;
    r_out_d  = r_out_q;
    dbz_d    = dbz_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        done = (state_q == S_DONE);
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        // DONE accepts start just like IDLE, allowing back-to-back operations.
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          r_d   = '0;
          cnt_d = '0;
          if (b_in == '0) begin
            q_out_d = '1;
            r_out_d = a_in;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        busy  = 1'b1;
        a_d   = a_iter;
        r_d   = r_iter;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          // Publish the final iteration's values directly so the result lands
          // on the same edge that enters DONE.
          q_out_d = a_iter;
          r_out_d = r_iter;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q_out       = q_out_q;
  assign r_out       = r_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider16.sv
// tb_seq_divider16 - directed and sweep checks for seq_divider16.
module tb_seq_divider16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] q_out;
  logic [15:0] r_out;
  logic        div_by_zero;

  int unsigned errors;
  int unsigned checks;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .q_out       (q_out),
    .r_out       (r_out),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start for one edge (the accepting edge k).
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count edges after acceptance until done is seen; bounded at 40.
  task automatic wait_done(output int unsigned lat, output int unsigned busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz);
    int unsigned lat, bc;
    launch(a, b);
    wait_done(lat, bc);
    chk({tag, "_lat"}, lat, (b == 16'd0) ? 32'd0 : 32'd16);
    chk({tag, "_busy"}, bc, (b == 16'd0) ? 32'd0 : 32'd16);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_q"}, {16'd0, q_out}, {16'd0, eq});
    chk({tag, "_r"}, {16'd0, r_out}, {16'd0, er});
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
  endtask

  initial begin
    int unsigned lat, bc;
    logic [15:0] ra, rb, eq, er;

    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", {16'd0, q_out}, 32'd0);
    chk("rst_r", {16'd0, r_out}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1. basic division, then done must be a single-cycle pulse with held result
    do_op("t1", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);
    tick();
    chk("t1_pulse", {31'd0, done}, 32'd0);
    chk("t1_hold_q", {16'd0, q_out}, 32'd14);
    chk("t1_hold_r", {16'd0, r_out}, 32'd2);

    // 2. extremes
    do_op("t2a", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
    tick();
    do_op("t2b", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0);
    tick();

    // 3. divide by zero
    do_op("t3", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1);
    tick();
    chk("t3_pulse", {31'd0, done}, 32'd0);

    // 4. start pulses during iterations 3 and 10 are ignored
    launch(16'd100, 16'd7);
    lat = 0;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      if (lat == 2 || lat == 9) begin
        start = 1'b1;
        a_in  = 16'd9;
        b_in  = 16'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("t4_lat", lat, 32'd16);
    chk("t4_busy", bc, 32'd16);
    chk("t4_q", {16'd0, q_out}, 32'd14);
    chk("t4_r", {16'd0, r_out}, 32'd2);
    tick();

    // 5. asynchronous reset in the middle of an operation
    launch(16'd100, 16'd7);
    repeat (8) tick();
    chk("t5_midbusy", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_q", {16'd0, q_out}, 32'd0);
    chk("t5_r", {16'd0, r_out}, 32'd0);
    chk("t5_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || done) bc++;
    end
    chk("t5_idle", bc, 32'd0);
    do_op("t5_rec", 16'd77, 16'd10, 16'd7, 16'd7, 1'b0);
    tick();

    // 6. back-to-back: start held in the DONE cycle
    launch(16'd100, 16'd7);
    wait_done(lat, bc);
    chk("t6a_q", {16'd0, q_out}, 32'd14);
    a_in  = 16'd50;
    b_in  = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_busy_now", {31'd0, busy}, 32'd1);
    wait_done(lat, bc);
    chk("t6_gap", lat + 1, 32'd17);
    chk("t6b_q", {16'd0, q_out}, 32'd10);
    chk("t6b_r", {16'd0, r_out}, 32'd0);
    chk("t6b_dbz", {31'd0, div_by_zero}, 32'd0);
    tick();

    // Sweep: reference quotient/remainder from the simulator's own operators
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'($urandom);
        1:       rb = 16'($urandom_range(1, 255));
        2:       rb = 16'($urandom_range(1, 15));
        default: rb = (n % 8 == 0) ? 16'd0 : ra;
      endcase
      if (rb == 16'd0) begin
        eq = 16'hFFFF;
        er = ra;
      end else begin
        eq = ra / rb;
        er = ra % rb;
      end
      launch(ra, rb);
      wait_done(lat, bc);
      chk("sw_q", {16'd0, q_out}, {16'd0, eq});
      chk("sw_r", {16'd0, r_out}, {16'd0, er});
      if (rb != 16'd0) begin
        chk("sw_inv", 32'(q_out) * 32'(rb) + 32'(r_out), 32'(ra));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
